vga_txt_writer: RTL and testbench

//  Write-side controller for the 80x30 text video buffer: accepts a byte stream
//  (ASCII + control codes), keeps a cursor, drives the buffer write port.

---
 rtl/vga_txt_pkg.sv | 29 ++
 rtl/vga_txt_cursor.sv | 69 ++++++
 rtl/vga_txt_writer.sv | 175 +++++++++++++++++
 tb/tb_vga_txt_writer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_txt_pkg.sv
// Shared definitions for the 80x30 text buffer: control codes, default
// geometry (also used by the read-side timing block) and writer states.
package vga_txt_pkg;

  localparam int unsigned DEF_COLS   = 80;
  localparam int unsigned DEF_ROWS   = 30;
  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned COL_W      = 7;
  localparam int unsigned ROW_W      = 5;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_LINE = 2'd1,
    ST_CLR_ALL  = 2'd2
  } wr_state_e;

  // Every handled control code sits below 0x20, so this alone decides
  // whether a byte lands in the buffer.
  function automatic logic is_printable(input logic [7:0] c);
    return c >= CH_SPACE;
  endfunction

endpackage

// File: rtl/vga_txt_cursor.sv
// Cursor column/row plus the linear base address of the current row.
// The base steps by COLS on each newline so no multiplier is needed.
module vga_txt_cursor
  import vga_txt_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              cr,
  input  logic              bs,
  input  logic              nl,
  input  logic              home,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] row_base,
  output logic [ADDR_W-1:0] nl_base,
  output logic              eol
);

  logic [COL_W-1:0]  col_d;
  logic [ROW_W-1:0]  row_d;
  logic [ADDR_W-1:0] row_base_d;
  logic              last_row;

  assign eol      = (col == COL_W'(COLS - 1));
  assign last_row = (row == ROW_W'(ROWS - 1));
  // Base of the row a newline would move to; the top uses it to aim a clear.
  assign nl_base  = last_row ? '0 : row_base + ADDR_W'(COLS);

  // Next cursor position; home beats newline beats advance beats CR/BS.
  always_comb begin
    col_d      = col;
    row_d      = row;
    row_base_d = row_base;
    if (home) begin
      col_d      = '0;
      row_d      = '0;
      row_base_d = '0;
    end else if (nl || (inc && eol)) begin
      col_d      = '0;
      row_d      = last_row ? '0 : row + ROW_W'(1);
      row_base_d = nl_base;
    end else if (inc) begin
      col_d = col + COL_W'(1);
    end else if (cr) begin
      col_d = '0;
    end else if (bs) begin
      if (col != '0) col_d = col - COL_W'(1);
    end
  end

  // Cursor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      col      <= col_d;
      row      <= row_d;
      row_base <= row_base_d;
    end
  end

endmodule

// File: rtl/vga_txt_writer.sv
// Write-side controller for the text buffer: turns a byte stream into cell
// writes, tracks the cursor and runs line / full-screen clear sequences.
// Handshake: a byte is taken on a rising edge where i_char_valid and
// o_char_ready are both high; while o_char_ready is low the source holds
// i_char/i_char_valid, so nothing is dropped here.
module vga_txt_writer
  import vga_txt_pkg::*;
#(
  parameter int unsigned COLS             = DEF_COLS,
  parameter int unsigned ROWS             = DEF_ROWS,
  parameter int unsigned ADDR_W           = DEF_ADDR_W,
  parameter logic [7:0]  FILL_CHAR        = 8'h20,
  parameter bit          CLEAR_ON_NEWLINE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_char,
  input  logic              i_char_valid,
  output logic              o_char_ready,
  output logic [7:0]        o_d_we,
  output logic [ADDR_W-1:0] o_addr_we,
  output logic              o_we_en_h,
  output logic [6:0]        o_cur_x,
  output logic [4:0]        o_cur_y,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_d, ready_d, busy_d;
  logic [7:0]        data_d;
  logic [ADDR_W-1:0] addr_d;
  logic              cur_inc, cur_cr, cur_bs, cur_nl, cur_home;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base, nl_base, cur_addr;
  logic              eol, accept;

  vga_txt_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .inc      (cur_inc),
    .cr       (cur_cr),
    .bs       (cur_bs),
    .nl       (cur_nl),
    .home     (cur_home),
    .col      (col),
    .row      (row),
    .row_base (row_base),
    .nl_base  (nl_base),
    .eol      (eol)
  );

  assign accept   = i_char_valid && o_char_ready;
  assign cur_addr = row_base + ADDR_W'(col);
  assign o_cur_x  = col;
  assign o_cur_y  = row;

  // Decode accepted bytes and step clear sequences. A clear's last write
  // returns to IDLE with ready still low, so ready/busy flip one cycle later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    data_d   = o_d_we;
    addr_d   = o_addr_we;
    ready_d  = 1'b1;
    busy_d   = 1'b0;
    cur_inc  = 1'b0;
    cur_cr   = 1'b0;
    cur_bs   = 1'b0;
    cur_nl   = 1'b0;
    cur_home = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (i_char)
            CH_BS: cur_bs = 1'b1;
            CH_CR: cur_cr = 1'b1;
            CH_LF: begin
              cur_nl = 1'b1;
              if (CLEAR_ON_NEWLINE) begin
                // First fill goes out with the newline itself.
                we_d    = 1'b1;
                data_d  = FILL_CHAR;
                addr_d  = nl_base;
                cnt_d   = ADDR_W'(1);
                state_d = ST_CLR_LINE;
                ready_d = 1'b0;
                busy_d  = 1'b1;
              end
            end
            CH_FF: begin
              we_d    = 1'b1;
              data_d  = FILL_CHAR;
              addr_d  = '0;
              cnt_d   = ADDR_W'(1);
              state_d = ST_CLR_ALL;
              ready_d = 1'b0;
              busy_d  = 1'b1;
            end
            default: begin
              if (is_printable(i_char)) begin
                we_d    = 1'b1;
                data_d  = i_char;
                addr_d  = cur_addr;
                cur_inc = 1'b1;
                if (eol && CLEAR_ON_NEWLINE) begin
                  // The character occupies this cycle; the fill starts next.
                  cnt_d   = '0;
                  state_d = ST_CLR_LINE;
                  ready_d = 1'b0;
                  busy_d  = 1'b1;
                end
              end
            end
          endcase
        end
      end
      ST_CLR_LINE: begin
        we_d    = 1'b1;
        data_d  = FILL_CHAR;
        addr_d  = row_base + cnt_q;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (cnt_q == LAST_COL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_CLR_ALL: begin
        we_d    = 1'b1;
        data_d  = FILL_CHAR;
        addr_d  = cnt_q;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (cnt_q == LAST_CELL) begin
          cnt_d    = '0;
          cur_home = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, clear counter and registered write-port / handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      o_we_en_h    <= 1'b0;
      o_d_we       <= '0;
      o_addr_we    <= '0;
      o_char_ready <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_we_en_h    <= we_d;
      o_d_we       <= data_d;
      o_addr_we    <= addr_d;
      o_char_ready <= ready_d;
      o_busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_vga_txt_writer.sv
// Bench for vga_txt_writer: byte driver, behavioural screen model feeding an
// expected-write queue, negedge write monitor, cursor vector table and
// hand-written sequences for wraps, clears and reset during a clear.
module tb_vga_txt_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam logic [7:0] FILL = 8'h20;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [7:0]        i_char = '0;
  logic              i_char_valid = 1'b0;
  logic              o_char_ready;
  logic [7:0]        o_d_we;
  logic [ADDR_W-1:0] o_addr_we;
  logic              o_we_en_h;
  logic [6:0]        o_cur_x;
  logic [4:0]        o_cur_y;
  logic              o_busy;

  vga_txt_writer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W),
    .FILL_CHAR(FILL), .CLEAR_ON_NEWLINE(1'b1)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_char       (i_char),
    .i_char_valid (i_char_valid),
    .o_char_ready (o_char_ready),
    .o_d_we       (o_d_we),
    .o_addr_we    (o_addr_we),
    .o_we_en_h    (o_we_en_h),
    .o_cur_x      (o_cur_x),
    .o_cur_y      (o_cur_y),
    .o_busy       (o_busy)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [ADDR_W+7:0] exp_q[$];
  int mx = 0, my = 0;
  int n_wr = 0, n_wr_busy = 0, n_fill_rdy_low = 0, n_rdy_low = 0;
  int last_wr_cyc = 0, prev_wr_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cur(input string name, input int x, input int y);
    check({name, "_x"}, 32'(o_cur_x), x);
    check({name, "_y"}, 32'(o_cur_y), y);
  endtask

  // ---------------- screen model ----------------
  task automatic push_wr(input int addr, input logic [7:0] d);
    exp_q.push_back({ADDR_W'(addr), d});
  endtask

  task automatic model_nl();
    mx = 0;
    my = (my == ROWS - 1) ? 0 : my + 1;
    for (int i = 0; i < COLS; i++) push_wr(my * COLS + i, FILL);
  endtask

  task automatic model_byte(input logic [7:0] c);
    case (c)
      8'h08: if (mx > 0) mx--;
      8'h0A: model_nl();
      8'h0C: begin
        for (int i = 0; i < COLS * ROWS; i++) push_wr(i, FILL);
        mx = 0;
        my = 0;
      end
      8'h0D: mx = 0;
      default: begin
        if (c >= 8'h20) begin
          push_wr(my * COLS + mx, c);
          mx++;
          if (mx == COLS) model_nl();
        end
      end
    endcase
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (!o_char_ready) n_rdy_low++;
      if (o_we_en_h) begin
        n_wr++;
        if (o_busy) n_wr_busy++;
        if (!o_char_ready && o_d_we == FILL) n_fill_rdy_low++;
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                   o_addr_we, o_d_we);
        end else begin
          check("write_cell", 32'({o_addr_we, o_d_we}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    i_rst_n = 1'b0;
    i_char_valid = 1'b0;
    exp_q.delete();
    mx = 0;
    my = 0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] c);
    int n = 0;
    i_char = c;
    i_char_valid = 1'b1;
    while (!o_char_ready && n < 5000) begin
      @(negedge i_clk);
      n++;
    end
    tests_run++;
    if (n >= 5000) begin
      tests_failed++;
      $display("FAIL send_timeout: byte 0x%0h not accepted within %0d cycles", c, n);
    end else begin
      model_byte(c);
    end
    @(negedge i_clk);
    i_char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    #2;
    while (!(o_char_ready && exp_q.size() == 0) && n < 6000) begin
      @(negedge i_clk);
      #2;
      n++;
    end
    check({name, "_idle"}, 32'(n < 6000), 1);
  endtask

  // ---------------- cursor vector table ----------------
  typedef struct {
    logic [7:0] c;
    int         ex;
    int         ey;
  } vec_t;
  vec_t vecs[13];

  initial begin
    int b_wr, b_busy, b_fill, b_rl;

    vecs[0]  = '{8'h41, 1, 0};  // 'A'
    vecs[1]  = '{8'h42, 2, 0};  // 'B'
    vecs[2]  = '{8'h08, 1, 0};  // BS
    vecs[3]  = '{8'h0D, 0, 0};  // CR
    vecs[4]  = '{8'h08, 0, 0};  // BS at column 0
    vecs[5]  = '{8'h01, 0, 0};  // ignored control
    vecs[6]  = '{8'h43, 1, 0};  // 'C'
    vecs[7]  = '{8'h0A, 0, 1};  // LF, clears row 1
    vecs[8]  = '{8'h1B, 0, 1};  // ignored control
    vecs[9]  = '{8'h44, 1, 1};  // 'D'
    vecs[10] = '{8'h7F, 2, 1};  // 0x7F is printable
    vecs[11] = '{8'h7E, 3, 1};  // '~'
    vecs[12] = '{8'h0D, 0, 1};  // CR

    // Reset values
    do_reset();
    #2;
    check("rst_ready", 32'(o_char_ready), 1);
    check("rst_we", 32'(o_we_en_h), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_data", 32'(o_d_we), 0);
    check("rst_addr", 32'(o_addr_we), 0);
    check_cur("rst_cur", 0, 0);

    // "AB" back to back
    b_rl = n_rdy_low;
    @(negedge i_clk);
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle("ab");
    check("ab_spacing", 32'(last_wr_cyc - prev_wr_cyc), 1);
    check("ab_ready_low", 32'(n_rdy_low - b_rl), 0);
    check_cur("ab_cur", 2, 0);

    // Table-driven cursor vectors
    do_reset();
    for (int i = 0; i < 13; i++) begin
      send_byte(vecs[i].c);
      wait_idle("vec");
      check_cur($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey);
    end

    // 80 printable characters: end-of-line wrap followed by a row clear
    do_reset();
    b_wr = n_wr; b_fill = n_fill_rdy_low; b_rl = n_rdy_low;
    for (int i = 0; i < COLS; i++) send_byte(8'h58);
    wait_idle("wrap");
    check("wrap_writes", 32'(n_wr - b_wr), 2 * COLS);
    check("wrap_fill_ready_low", 32'(n_fill_rdy_low - b_fill), COLS);
    check("wrap_ready_low_cycles", 32'((n_rdy_low - b_rl) >= COLS), 1);
    check_cur("wrap_cur", 0, 1);

    // LF on the last row wraps to row 0 and clears it
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    wait_idle("toprow");
    check_cur("toprow_pre", 5, ROWS - 1);
    send_byte(8'h0A);
    check("lf_first_we", 32'(o_we_en_h), 1);
    check("lf_first_addr", 32'(o_addr_we), 0);
    check("lf_first_data", 32'(o_d_we), 32'(FILL));
    check("lf_ready_low", 32'(o_char_ready), 0);
    wait_idle("toprow_lf");
    check_cur("toprow_post", 0, 0);

    // Q, BS, BS, CR at (0,3)
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    wait_idle("q_pre");
    check_cur("q_start", 0, 3);
    send_byte(8'h51); wait_idle("q"); check_cur("q_q", 1, 3);
    send_byte(8'h08); wait_idle("q"); check_cur("q_bs1", 0, 3);
    send_byte(8'h08); wait_idle("q"); check_cur("q_bs2", 0, 3);
    send_byte(8'h0D); wait_idle("q"); check_cur("q_cr", 0, 3);

    // Form feed: whole-screen clear from a non-home cursor
    send_byte(8'h5A);
    wait_idle("ff_pre");
    b_wr = n_wr; b_busy = n_wr_busy;
    send_byte(8'h0C);
    wait_idle("ff");
    check("ff_writes", 32'(n_wr - b_wr), COLS * ROWS);
    check("ff_busy_writes", 32'(n_wr_busy - b_busy), COLS * ROWS);
    check("ff_ready_after_last", 32'(cyc - last_wr_cyc), 1);
    check("ff_busy_end", 32'(o_busy), 0);
    check_cur("ff_cur", 0, 0);

    // Reset in the middle of a full clear
    send_byte(8'h41);
    send_byte(8'h0C);
    repeat (100) @(negedge i_clk);
    check("midclr_busy_before", 32'(o_busy), 1);
    i_rst_n = 1'b0;
    exp_q.delete();
    mx = 0;
    my = 0;
    #1;
    check("midclr_we", 32'(o_we_en_h), 0);
    check("midclr_busy", 32'(o_busy), 0);
    check_cur("midclr_cur", 0, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    check("midclr_ready_after", 32'(o_char_ready), 1);
    send_byte(8'h41);
    wait_idle("midclr_post");
    check_cur("midclr_post_cur", 1, 0);

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
